adder_pipe_acc: RTL and testbench

- Parametrised, pipelined WIDTH-bit adder for neuron datapaths, with valid/ready handshakes on input and output.
- Supports two modes: plain add (a+b+cin), and accumulate (acc+a) into an internal accumulator used for weighted-sum reduction.
- Carry ripples through STAGES equal chunks, with one chunk per pipeline stage and registers between stages.

---
 rtl/adder_pipe_pkg.sv | 22 ++
 rtl/adder_chunk.sv | 26 ++
 rtl/adder_pipe_acc.sv | 194 +++++++++++++++++++
 tb/tb_adder_pipe_acc.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// adder_pipe_pkg: shared constants and helpers for the pipelined adder.
// Mode encodings, chunk sizing and signed saturation limits.
package adder_pipe_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  // Returns 0 for an illegal split so the top can reject it at elaboration.
  function automatic int chunk_width(input int width, input int stages);
    if (stages <= 0 || (width % stages) != 0) return 0;
    return width / stages;
  endfunction

  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational W-bit ripple of full-adder cells.
// Ports: a, b, cin in; r, cout, c_msb (carry into bit W-1) out.
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] r,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign r[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/adder_pipe_acc.sv
// adder_pipe_acc: STAGES-deep pipelined WIDTH-bit adder with accumulator.
// Ports: clk, rst_n; in_valid/in_ready, a, b, cin, mode, acc_clear;
// out_valid/out_ready, sum, cout, overflow.
// Build option: ADDER_PIPE_SAT_EN clamps sum to signed limits on overflow.
module adder_pipe_acc
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  input  logic             acc_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (CHUNK == 0) begin : g_bad_cfg
    $error("WIDTH must be a non-zero multiple of STAGES");
  end

`ifdef ADDER_PIPE_SAT_EN
  localparam logic [63:0] SMAX64 = sat_max(WIDTH);
  localparam logic [63:0] SMIN64 = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] SMAX = SMAX64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN = SMIN64[WIDTH-1:0];
`endif

  logic stall, accept, hs, acc_mode;

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic [WIDTH-1:0] r_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] m_q, m_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] sa [STAGES];
  logic [WIDTH-1:0] sb [STAGES];
  logic [WIDTH-1:0] sr [STAGES];
  logic [STAGES-1:0] sc, sv, sm;

  logic [CHUNK-1:0] cr [STAGES];
  logic [STAGES-1:0] co;
  logic             c_msb;
  logic             ovf_w;
  logic [WIDTH-1:0] last_sum;

  assign stall    = v_q[LAST] && !out_ready;
  assign in_ready = !stall && !busy_q;
  assign accept   = in_valid && in_ready;
  assign acc_mode = (mode == MODE_ACC);
  assign hs       = v_q[LAST] && out_ready;

  // Stage 0 reads the ports; later stages read the previous register.
  always_comb begin
    sa[0] = a;
    sb[0] = acc_mode ? acc_q : b;
    sc[0] = acc_mode ? 1'b0 : cin;
    sr[0] = '0;
    sv[0] = accept;
    sm[0] = acc_mode;
    for (int k = 1; k < STAGES; k++) begin
      sa[k] = a_q[k-1];
      sb[k] = b_q[k-1];
      sc[k] = c_q[k-1];
      sr[k] = r_q[k-1];
      sv[k] = v_q[k-1];
      sm[k] = m_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == LAST) begin : g_top
      adder_chunk #(.W(CHUNK)) u_chunk (
        .a     (sa[k][k*CHUNK +: CHUNK]),
        .b     (sb[k][k*CHUNK +: CHUNK]),
        .cin   (sc[k]),
        .r     (cr[k]),
        .cout  (co[k]),
        .c_msb (c_msb)
      );
    end else begin : g_low
      logic c_msb_unused;
      adder_chunk #(.W(CHUNK)) u_chunk (
        .a     (sa[k][k*CHUNK +: CHUNK]),
        .b     (sb[k][k*CHUNK +: CHUNK]),
        .cin   (sc[k]),
        .r     (cr[k]),
        .cout  (co[k]),
        .c_msb (c_msb_unused)
      );
    end
  end

  // Overflow implies equal operand signs, so a's MSB picks the limit.
  always_comb begin
    ovf_w    = c_msb ^ co[LAST];
    last_sum = sr[LAST];
    last_sum[LAST*CHUNK +: CHUNK] = cr[LAST];
`ifdef ADDER_PIPE_SAT_EN
    if (ovf_w) last_sum = sa[LAST][WIDTH-1] ? SMIN : SMAX;
`endif
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      r_d[k] = r_q[k];
      c_d[k] = c_q[k];
      v_d[k] = v_q[k];
      m_d[k] = m_q[k];
      if (!stall) begin
        a_d[k] = sa[k];
        b_d[k] = sb[k];
        c_d[k] = co[k];
        v_d[k] = sv[k];
        m_d[k] = sm[k];
        if (k == LAST) begin
          r_d[k] = last_sum;
        end else begin
          r_d[k] = sr[k];
          r_d[k][k*CHUNK +: CHUNK] = cr[k];
        end
      end
    end
    ovf_d = stall ? ovf_q : ovf_w;
  end

  // Clear is applied last so it wins over a coincident writeback.
  always_comb begin
    acc_d  = acc_q;
    busy_d = busy_q;
    if (hs && m_q[LAST]) begin
      acc_d  = r_q[LAST];
      busy_d = 1'b0;
    end
    if (acc_clear) acc_d = '0;
    if (accept && acc_mode) busy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
      c_q    <= '0;
      v_q    <= '0;
      m_q    <= '0;
      ovf_q  <= 1'b0;
      acc_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        r_q[k] <= r_d[k];
      end
      c_q    <= c_d;
      v_q    <= v_d;
      m_q    <= m_d;
      ovf_q  <= ovf_d;
      acc_q  <= acc_d;
      busy_q <= busy_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = r_q[LAST];
  assign cout      = c_q[LAST];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_adder_pipe_acc.sv
// tb_adder_pipe_acc: scoreboard bench for adder_pipe_acc (16 bits, 4 stages).
// Define ADDER_PIPE_SAT_EN for both bench and RTL to check saturation.
module tb_adder_pipe_acc;
  import adder_pipe_pkg::*;

  localparam int W = 16;
  localparam int S = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         mode = 1'b0;
  logic         acc_clear = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  exp_t         sbq [$];
  logic [W-1:0] acc_m = '0;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  adder_pipe_acc #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .mode      (mode),
    .acc_clear (acc_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci);
    logic [W:0] f;
    exp_t       e;
    f   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.c = f[W];
    e.o = (x[W-1] == y[W-1]) && (f[W-1] != x[W-1]);
    e.s = f[W-1:0];
`ifdef ADDER_PIPE_SAT_EN
    if (e.o) e.s = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return e;
  endfunction

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic md);
    exp_t e;
    int   n;
    e = (md == MODE_ACC) ? model(x, acc_m, 1'b0) : model(x, y, ci);
    @(negedge clk);
    a = x; b = y; cin = ci; mode = md; in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sbq.push_back(e);
      if (md == MODE_ACC) acc_m = e.s;
      #1;
      in_valid = 1'b0;
      if (md == MODE_ACC) chk("busy_rdy", 32'(in_ready), 32'd0);
    end
  endtask

  task automatic clear_acc();
    @(negedge clk);
    acc_clear = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    acc_m = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        chk("sum", 32'(sum), 32'(sbq[0].s));
        chk("cout", 32'(cout), 32'(sbq[0].c));
        chk("ovf", 32'(overflow), 32'(sbq[0].o));
        if (out_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rdy_after_rst", 32'(in_ready), 32'd1);

    send(16'h00FF, 16'h0001, 1'b0, MODE_ADD);
    repeat (3) @(negedge clk);
    #1;
    chk("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("lat", 32'(out_valid), 32'd1);
    send(16'hFFFF, 16'h0000, 1'b1, MODE_ADD);
    send(16'h7FFF, 16'h0001, 1'b0, MODE_ADD);
    send(16'h8000, 16'h8000, 1'b0, MODE_ADD);
    for (int i = 0; i < 8; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), MODE_ADD);
    drain();

    fork
      begin
        for (int i = 0; i < 10; i++)
          send(16'(i), 16'd100, 1'b0, MODE_ADD);
      end
      begin
        repeat (40) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    clear_acc();
    send(16'd5, 16'd0, 1'b0, MODE_ACC);
    send(16'd10, 16'd0, 1'b0, MODE_ACC);
    send(16'd20, 16'd0, 1'b0, MODE_ACC);
    drain();
    clear_acc();
    send(16'd7, 16'd0, 1'b0, MODE_ACC);
    drain();

    @(negedge clk);
    out_ready = 1'b0;
    send(16'd4, 16'd0, 1'b0, MODE_ACC);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("clr_wait", 32'(out_valid), 32'd1);
    @(negedge clk);
    acc_clear = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    acc_m = '0;
    drain();
    send(16'd2, 16'd0, 1'b0, MODE_ACC);
    drain();

    clear_acc();
    send(16'd3, 16'd4, 1'b0, MODE_ADD);
    send(16'd9, 16'd0, 1'b0, MODE_ACC);
    drain();
    send(16'd1, 16'd0, 1'b0, MODE_ACC);
    drain();

    @(negedge clk);
    out_ready = 1'b0;
    send(16'd1, 16'd2, 1'b0, MODE_ADD);
    send(16'd3, 16'd4, 1'b0, MODE_ADD);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    acc_m = '0;
    @(negedge clk);
    #1;
    chk("mid_rst_rdy", 32'(in_ready), 32'd1);
    repeat (8) @(negedge clk);
    send(16'd1, 16'd0, 1'b0, MODE_ACC);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
